// File: rtl/eth_mdio_pkg.sv
// Shared constants, state encoding and command payload for the clause-22 MDIO frame sequencer.
package eth_mdio_pkg;

   localparam logic [1:0] ST_CODE = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [1:0] TA_WR   = 2'b10;

   localparam int unsigned HDR_BITS  = 14;
   localparam int unsigned DATA_BITS = 16;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned SAMP_W    = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_GAP
   } mdio_state_e;

   typedef struct packed {
      logic       write;
      logic [4:0] phy_addr;
      logic [4:0] reg_addr;
   } mdio_cmd_t;

   // ST, OP, PHYAD, REGAD packed MSB first in transmit order
   function automatic logic [HDR_BITS-1:0] mdio_hdr(input mdio_cmd_t cmd);
      return {ST_CODE, (cmd.write ? OP_WR : OP_RD), cmd.phy_addr, cmd.reg_addr};
   endfunction

endpackage

// File: rtl/eth_mdio_shreg.sv
// 16-bit data shifter: parallel load, MSB-first shift-out and LSB-side shift-in capture.
module eth_mdio_shreg
   import eth_mdio_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] load_data,
   input  logic                 out_en,
   input  logic                 cap_en,
   input  logic                 sin,
   output logic [DATA_BITS-1:0] data
);

   logic [DATA_BITS-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = load_data;
      end else if (out_en) begin
         data_d = {data_q[DATA_BITS-2:0], 1'b0};
      end else if (cap_en) begin
         data_d = {data_q[DATA_BITS-2:0], sin};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/eth_mdio_ctrl.sv
// MDIO clause-22 frame sequencer driven by MdcEn/MdcEn_n strobes.
// Define ETH_MDIO_SCAN_EN to add background polling of one PHY register (ScanEn/ScanStat).
module eth_mdio_ctrl
   import eth_mdio_pkg::*;
#(
   parameter int unsigned PREAMBLE_LEN = 32,
   parameter int unsigned IDLE_GAP     = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MdcEn,
   input  logic        MdcEn_n,
   input  logic        Mdi,
   input  logic        CmdValid,
   output logic        CmdReady,
   input  logic        CmdWrite,
   input  logic [4:0]  CmdPhyAddr,
   input  logic [4:0]  CmdRegAddr,
   input  logic [15:0] CmdWrData,
   input  logic        NoPre,
`ifdef ETH_MDIO_SCAN_EN
   input  logic        ScanEn,
   input  logic [4:0]  ScanPhyAddr,
   input  logic [4:0]  ScanRegAddr,
   output logic [15:0] ScanStat,
`endif
   output logic        Mdo,
   output logic        MdoEn,
   output logic        Busy,
   output logic [15:0] RdData,
   output logic        RdValid
);

   mdio_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SAMP_W-1:0]    samp_q, samp_d;
   mdio_cmd_t            cmd_q, cmd_d;
   logic                 mdo_q, mdo_d;
   logic                 mdo_en_q, mdo_en_d;
   logic                 busy_q, busy_d;
   logic [15:0]          rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 rd_per_q, rd_per_d;
`ifdef ETH_MDIO_SCAN_EN
   logic                 scan_q, scan_d;
   logic [15:0]          scan_stat_q, scan_stat_d;
`endif

   logic                 fall, rise, accept, scan_go, start;
   logic                 sh_load, sh_out, sh_cap;
   logic [DATA_BITS-1:0] sh_data;
   logic [DATA_BITS-1:0] cap_word;
   logic [HDR_BITS-1:0]  hdr;
   logic [3:0]           hdr_idx;

   // MdcEn_n wins when both strobes collide; no sample is taken then
   assign fall = MdcEn_n;
   assign rise = MdcEn & ~MdcEn_n;

`ifdef ETH_MDIO_SCAN_EN
   assign scan_go = (state_q == S_IDLE) & ScanEn & ~CmdValid;
`else
   assign scan_go = 1'b0;
`endif

   assign CmdReady = (state_q == S_IDLE) & ~scan_go;
   assign accept   = CmdValid & CmdReady;
   assign start    = accept | scan_go;
   assign sh_load  = start;
   assign hdr      = mdio_hdr(cmd_q);
   assign hdr_idx  = 4'(HDR_BITS - 1) - cnt_q[3:0];
   assign cap_word = {sh_data[DATA_BITS-2:0], Mdi};

   eth_mdio_shreg u_shreg (
      .clk       (Clk),
      .rst       (Reset),
      .load      (sh_load),
      .load_data (CmdWrData),
      .out_en    (sh_out),
      .cap_en    (sh_cap),
      .sin       (Mdi),
      .data      (sh_data)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      samp_d     = samp_q;
      cmd_d      = cmd_q;
      mdo_d      = mdo_q;
      mdo_en_d   = mdo_en_q;
      busy_d     = busy_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_per_d   = rd_per_q;
      sh_out     = 1'b0;
      sh_cap     = 1'b0;
`ifdef ETH_MDIO_SCAN_EN
      scan_d      = scan_q;
      scan_stat_d = scan_stat_q;
`endif

      // read data is captured mid-period, on the Mdc rising strobe
      if (rise && rd_per_q) begin
         sh_cap = 1'b1;
         samp_d = samp_q + SAMP_W'(1);
         if (samp_q == SAMP_W'(DATA_BITS - 1)) begin
`ifdef ETH_MDIO_SCAN_EN
            if (scan_q) scan_stat_d = cap_word;
            else
`endif
            begin
               rd_data_d  = cap_word;
               rd_valid_d = 1'b1;
            end
         end
      end

      if (state_q == S_IDLE) begin
         if (start) begin
            cmd_d.write    = CmdWrite;
            cmd_d.phy_addr = CmdPhyAddr;
            cmd_d.reg_addr = CmdRegAddr;
`ifdef ETH_MDIO_SCAN_EN
            scan_d = ~accept;
            if (!accept) begin
               cmd_d.write    = 1'b0;
               cmd_d.phy_addr = ScanPhyAddr;
               cmd_d.reg_addr = ScanRegAddr;
            end
`endif
            busy_d  = 1'b1;
            cnt_d   = '0;
            samp_d  = '0;
            state_d = NoPre ? S_HDR : S_PRE;
         end
      end else if (fall) begin
         // state names the bit that goes out on this falling strobe
         cnt_d    = cnt_q + CNT_W'(1);
         rd_per_d = 1'b0;
         case (state_q)
            S_PRE: begin
               mdo_d    = 1'b1;
               mdo_en_d = 1'b1;
               if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                  state_d = S_HDR;
                  cnt_d   = '0;
               end
            end
            S_HDR: begin
               mdo_d    = hdr[hdr_idx];
               mdo_en_d = 1'b1;
               if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
                  state_d = S_TA;
                  cnt_d   = '0;
               end
            end
            S_TA: begin
               mdo_d    = cmd_q.write & (cnt_q[0] ? TA_WR[0] : TA_WR[1]);
               mdo_en_d = cmd_q.write;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               if (cmd_q.write) begin
                  mdo_d    = sh_data[DATA_BITS-1];
                  mdo_en_d = 1'b1;
                  sh_out   = 1'b1;
               end else begin
                  mdo_d    = 1'b0;
                  mdo_en_d = 1'b0;
                  rd_per_d = 1'b1;
               end
               if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
               end
            end
            S_GAP: begin
               mdo_d    = 1'b0;
               mdo_en_d = 1'b0;
               if (cnt_q == CNT_W'(IDLE_GAP)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         samp_q      <= '0;
         cmd_q       <= '0;
         mdo_q       <= 1'b0;
         mdo_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_per_q    <= 1'b0;
`ifdef ETH_MDIO_SCAN_EN
         scan_q      <= 1'b0;
         scan_stat_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         samp_q      <= samp_d;
         cmd_q       <= cmd_d;
         mdo_q       <= mdo_d;
         mdo_en_q    <= mdo_en_d;
         busy_q      <= busy_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_per_q    <= rd_per_d;
`ifdef ETH_MDIO_SCAN_EN
         scan_q      <= scan_d;
         scan_stat_q <= scan_stat_d;
`endif
      end
   end

   assign Mdo     = mdo_q;
   assign MdoEn   = mdo_en_q;
   assign Busy    = busy_q;
   assign RdData  = rd_data_q;
   assign RdValid = rd_valid_q;
`ifdef ETH_MDIO_SCAN_EN
   assign ScanStat = scan_stat_q;
`endif

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Directed bench for eth_mdio_ctrl: frame bit capture per Mdc period plus a simple PHY read model.
module tb_eth_mdio_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Mdi = 1'b1;
   logic        CmdValid = 1'b0;
   logic        CmdWrite = 1'b0;
   logic        NoPre = 1'b0;
   logic [4:0]  CmdPhyAddr = 5'h00;
   logic [4:0]  CmdRegAddr = 5'h00;
   logic [15:0] CmdWrData = 16'h0000;
   logic        MdcEn, MdcEn_n, CmdReady, Mdo, MdoEn, Busy, RdValid;
   logic [15:0] RdData;
`ifdef ETH_MDIO_SCAN_EN
   logic        ScanEn = 1'b0;
   logic [4:0]  ScanPhyAddr = 5'h00;
   logic [4:0]  ScanRegAddr = 5'h00;
   logic [15:0] ScanStat;
`endif

   logic [2:0]  phase = 3'd0;
   int          checks = 0;
   int          errors = 0;
   int          drv_total = 0;
   int          drv_base = 0;
   int          rdv_total = 0;
   int          frame_no = 0;
   int          data_start = 48;
   bit          mon_on = 1'b0;
   logic [15:0] phy_word = 16'h0000;
   logic        bit_mdo [0:127];
   logic        bit_en  [0:127];
   int          bit_tag [0:127];

   eth_mdio_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .MdcEn       (MdcEn),
      .MdcEn_n     (MdcEn_n),
      .Mdi         (Mdi),
      .CmdValid    (CmdValid),
      .CmdReady    (CmdReady),
      .CmdWrite    (CmdWrite),
      .CmdPhyAddr  (CmdPhyAddr),
      .CmdRegAddr  (CmdRegAddr),
      .CmdWrData   (CmdWrData),
      .NoPre       (NoPre),
`ifdef ETH_MDIO_SCAN_EN
      .ScanEn      (ScanEn),
      .ScanPhyAddr (ScanPhyAddr),
      .ScanRegAddr (ScanRegAddr),
      .ScanStat    (ScanStat),
`endif
      .Mdo         (Mdo),
      .MdoEn       (MdoEn),
      .Busy        (Busy),
      .RdData      (RdData),
      .RdValid     (RdValid)
   );

   always #5 Clk = ~Clk;

   // Mdc period of 8 Clk: falling strobe at phase 7, rising strobe at phase 3
   always @(posedge Clk) phase <= phase + 3'd1;
   assign MdcEn_n = (phase == 3'd7);
   assign MdcEn   = (phase == 3'd3);

   // Records each Mdc period's Mdo/MdoEn and plays the PHY side of read data
   always @(negedge Clk) begin
      int j;
      if (MdcEn_n) drv_total = drv_total + 1;
      if (RdValid) rdv_total = rdv_total + 1;
      if (MdcEn && !MdcEn_n) begin
         j = drv_total - drv_base - 1;
         if (mon_on && j >= 0 && j < 128) begin
            bit_mdo[j] = Mdo;
            bit_en[j]  = MdoEn;
            bit_tag[j] = frame_no;
         end
         if (mon_on && j >= data_start && j < data_start + 16)
            Mdi = phy_word[15 - (j - data_start)];
         else
            Mdi = 1'b1;
      end
   end

   task automatic send_cmd(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input logic np, output bit ok);
      ok = 1'b0;
      @(negedge Clk);
      CmdWrite = wr; CmdPhyAddr = phy; CmdRegAddr = rg; CmdWrData = wd; NoPre = np;
      CmdValid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (CmdReady) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      @(posedge Clk);
      #1;
      CmdValid = 1'b0;
      frame_no = frame_no + 1;
      drv_base = drv_total;
      mon_on   = 1'b1;
   endtask

   task automatic wait_idle(output bit ok, output int edges, output logic rdy);
      ok = 1'b0;
      rdy = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge Clk);
         #1;
         if (!Busy) begin
            ok  = 1'b1;
            rdy = CmdReady;
            break;
         end
      end
      edges  = drv_total - drv_base;
      mon_on = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      #1;
      checks++; if (Mdo !== 1'b0) begin errors++; $display("FAIL rst_mdo: got %b want 0", Mdo); end
      checks++; if (MdoEn !== 1'b0) begin errors++; $display("FAIL rst_mdoen: got %b want 0", MdoEn); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", Busy); end
      checks++; if (RdData !== 16'h0000) begin errors++; $display("FAIL rst_rddata: got %h want 0000", RdData); end
      checks++; if (RdValid !== 1'b0) begin errors++; $display("FAIL rst_rdvalid: got %b want 0", RdValid); end
      checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL rst_cmdready: got %b want 1", CmdReady); end
      Reset = 1'b0;
   endtask

   task automatic test_write_pre();
      bit ok; int edges; logic rdy; int bad_mdo; int bad_en;
      logic [63:0] exp;
      exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h8000};
      send_cmd(1'b1, 5'h01, 5'h00, 16'h8000, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_accept: CmdReady never seen"); end
      wait_idle(ok, edges, rdy);
      checks++; if (!ok) begin errors++; $display("FAIL wr_timeout: Busy still 1"); end
      bad_mdo = 0; bad_en = 0;
      for (int j = 0; j < 64; j++) begin
         if (bit_tag[j] != frame_no || bit_mdo[j] !== exp[63-j]) bad_mdo++;
         if (bit_tag[j] != frame_no || bit_en[j] !== 1'b1) bad_en++;
      end
      checks++; if (bad_mdo != 0) begin errors++; $display("FAIL wr_mdo: %0d wrong bits, want 0", bad_mdo); end
      checks++; if (bad_en != 0) begin errors++; $display("FAIL wr_mdoen: %0d wrong bits, want 0", bad_en); end
      checks++;
      if (bit_tag[64] != frame_no || bit_en[64] !== 1'b0 || bit_mdo[64] !== 1'b0) begin
         errors++; $display("FAIL wr_gap: en=%b mdo=%b want 0 0", bit_en[64], bit_mdo[64]);
      end
      checks++; if (edges != 66) begin errors++; $display("FAIL wr_busy_len: got %0d strobes want 66", edges); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready_at_idle: got %b want 1", rdy); end
   endtask

   task automatic test_read();
      bit ok; int edges; logic rdy; int bad_mdo; int bad_en; int rdv_base;
      logic [45:0] exp;
      exp = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h02};
      phy_word   = 16'h0141;
      data_start = 48;
      rdv_base   = rdv_total;
      send_cmd(1'b0, 5'h1F, 5'h02, 16'hFFFF, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rd_accept: CmdReady never seen"); end
      wait_idle(ok, edges, rdy);
      checks++; if (!ok) begin errors++; $display("FAIL rd_timeout: Busy still 1"); end
      bad_mdo = 0; bad_en = 0;
      for (int j = 0; j < 64; j++) begin
         if (j < 46 && (bit_tag[j] != frame_no || bit_mdo[j] !== exp[45-j])) bad_mdo++;
         if (bit_tag[j] != frame_no || bit_en[j] !== (j < 46 ? 1'b1 : 1'b0)) bad_en++;
      end
      checks++; if (bad_mdo != 0) begin errors++; $display("FAIL rd_hdr_mdo: %0d wrong bits, want 0", bad_mdo); end
      checks++; if (bad_en != 0) begin errors++; $display("FAIL rd_mdoen: %0d wrong bits, want 0", bad_en); end
      checks++; if (RdData !== 16'h0141) begin errors++; $display("FAIL rd_data: got %h want 0141", RdData); end
      repeat (20) @(negedge Clk);
      #1;
      checks++;
      if (rdv_total - rdv_base != 1) begin
         errors++; $display("FAIL rd_valid_pulses: got %0d want 1", rdv_total - rdv_base);
      end
      checks++; if (edges != 66) begin errors++; $display("FAIL rd_busy_len: got %0d strobes want 66", edges); end
   endtask

   task automatic test_nopre_write();
      bit ok; int edges; logic rdy; int bad_mdo; int bad_en;
      logic [31:0] exp;
      exp = {2'b01, 2'b01, 5'h0A, 5'h13, 2'b10, 16'hA5C3};
      send_cmd(1'b1, 5'h0A, 5'h13, 16'hA5C3, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL np_accept: CmdReady never seen"); end
      wait_idle(ok, edges, rdy);
      checks++; if (!ok) begin errors++; $display("FAIL np_timeout: Busy still 1"); end
      bad_mdo = 0; bad_en = 0;
      for (int j = 0; j < 32; j++) begin
         if (bit_tag[j] != frame_no || bit_mdo[j] !== exp[31-j]) bad_mdo++;
         if (bit_tag[j] != frame_no || bit_en[j] !== 1'b1) bad_en++;
      end
      checks++; if (bit_mdo[0] !== 1'b0) begin errors++; $display("FAIL np_first_bit: got %b want 0", bit_mdo[0]); end
      checks++; if (bad_mdo != 0) begin errors++; $display("FAIL np_mdo: %0d wrong bits, want 0", bad_mdo); end
      checks++; if (bad_en != 0) begin errors++; $display("FAIL np_mdoen: %0d wrong bits, want 0", bad_en); end
      checks++; if (bit_en[32] !== 1'b0) begin errors++; $display("FAIL np_gap: en=%b want 0", bit_en[32]); end
      checks++; if (edges != 34) begin errors++; $display("FAIL np_busy_len: got %0d strobes want 34", edges); end
      checks++; if (RdData !== 16'h0141) begin errors++; $display("FAIL np_rddata_hold: got %h want 0141", RdData); end
   endtask

   task automatic test_accept_on_strobe();
      int cyc; int first_en; int overlap; int bad_mdo; int edges; bit done;
      logic [31:0] exp;
      exp = {2'b01, 2'b01, 5'h03, 5'h04, 2'b10, 16'h1234};
      for (int i = 0; i < 16; i++) begin
         @(negedge Clk);
         if (MdcEn_n) break;
      end
      CmdWrite = 1'b1; CmdPhyAddr = 5'h03; CmdRegAddr = 5'h04; CmdWrData = 16'h1234; NoPre = 1'b1;
      CmdValid = 1'b1;
      checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL strobe_ready: got %b want 1", CmdReady); end
      @(posedge Clk);
      #1;
      frame_no = frame_no + 1;
      drv_base = drv_total;
      mon_on   = 1'b1;
      // keep requesting with different fields while the frame runs
      CmdWrite = 1'b0; CmdPhyAddr = 5'h1E; CmdRegAddr = 5'h1B; CmdWrData = 16'hFFFF;
      cyc = 0; first_en = 0; overlap = 0; done = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge Clk);
         #1;
         cyc++;
         if (Busy && CmdReady) overlap++;
         if (MdoEn && first_en == 0) first_en = cyc;
         if (drv_total - drv_base >= 20) CmdValid = 1'b0;
         if (!Busy) begin
            done = 1'b1;
            break;
         end
      end
      CmdValid = 1'b0;
      edges  = drv_total - drv_base;
      mon_on = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL strobe_timeout: Busy still 1"); end
      checks++; if (first_en != 8) begin errors++; $display("FAIL strobe_first_bit: got cycle %0d want 8", first_en); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL busy_ready_overlap: got %0d cycles want 0", overlap); end
      bad_mdo = 0;
      for (int j = 0; j < 32; j++)
         if (bit_tag[j] != frame_no || bit_mdo[j] !== exp[31-j]) bad_mdo++;
      checks++; if (bad_mdo != 0) begin errors++; $display("FAIL strobe_frame: %0d wrong bits, want 0", bad_mdo); end
      checks++; if (edges != 34) begin errors++; $display("FAIL strobe_busy_len: got %0d strobes want 34", edges); end
      repeat (12) @(negedge Clk);
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL strobe_no_reaccept: Busy=%b want 0", Busy); end
   endtask

   task automatic test_reset_mid();
      bit ok; bit hit; int edges; logic rdy; int bad_mdo;
      logic [31:0] exp;
      exp = {2'b01, 2'b01, 5'h11, 5'h1C, 2'b10, 16'h0F0F};
      send_cmd(1'b1, 5'h05, 5'h06, 16'hFFFF, 1'b0, ok);
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge Clk);
         #1;
         if (drv_total - drv_base >= 56) begin
            hit = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge Clk);
      #1;
      checks++; if (!hit) begin errors++; $display("FAIL mid_reach_bit7: frame never reached data bit 7"); end
      checks++;
      if (MdoEn !== 1'b1 || Mdo !== 1'b1) begin
         errors++; $display("FAIL mid_pre_reset: en=%b mdo=%b want 1 1", MdoEn, Mdo);
      end
      Reset = 1'b1;
      #1;
      checks++; if (MdoEn !== 1'b0) begin errors++; $display("FAIL mid_rst_mdoen: got %b want 0", MdoEn); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", Busy); end
      checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", CmdReady); end
      mon_on = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      send_cmd(1'b1, 5'h11, 5'h1C, 16'h0F0F, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_reaccept: CmdReady never seen"); end
      wait_idle(ok, edges, rdy);
      bad_mdo = 0;
      for (int j = 0; j < 32; j++)
         if (bit_tag[j] != frame_no || bit_mdo[j] !== exp[31-j]) bad_mdo++;
      checks++; if (bad_mdo != 0) begin errors++; $display("FAIL mid_new_frame: %0d wrong bits, want 0", bad_mdo); end
      checks++; if (edges != 34) begin errors++; $display("FAIL mid_busy_len: got %0d strobes want 34", edges); end
      checks++; if (RdData !== 16'h0000) begin errors++; $display("FAIL mid_rddata_cleared: got %h want 0000", RdData); end
`ifdef ETH_MDIO_SCAN_EN
      checks++; if (ScanStat !== 16'h0000) begin errors++; $display("FAIL scanstat_idle: got %h want 0000", ScanStat); end
`endif
   endtask

   initial begin
      test_reset();
      test_write_pre();
      test_read();
      test_nopre_write();
      test_accept_on_strobe();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
